multi_cycle_cpu: RTL and testbench
==================================

// Module: multi_cycle_cpu
// PURPOSE
//  Multi-cycle MIPS-subset core: a parametrised successor to the single-cycle SimpleCPU.
//  One ALU and one unified memory port are shared across the FETCH/DECODE/EXEC/MEM/WB states.
//  Memory is external, behind a req/ready handshake, so slow memories are tolerated.
//  The register file, ALU, ALU control and PC are internal to this block.
// PARAMETERS
//  ADDR_W    32  PC/memory address width (8..32); PC arithmetic wraps modulo 2^ADDR_W
//  REG_NUM   32  architectural registers (8,16,32); register index = low log2(REG_NUM) bits of field
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  mem_req    out  1       memory access request; held until mem_ready
//  mem_we     out  1       1 = write (sw), 0 = read (fetch/lw)
//  mem_addr   out  ADDR_W  byte address, word aligned (low 2 bits forced 0)
//  mem_wdata  out  32      store data (rt)
//  mem_rdata  in   32      read data; valid in the cycle mem_ready=1
//  mem_ready  in   1       access completes in the cycle mem_req & mem_ready
//  pc_out     out  ADDR_W  current PC
//  retire     out  1       1-cycle pulse as each instruction completes
//  illegal    out  1       sticky; set on an unsupported opcode/funct
// BEHAVIOUR
//  Reset: PC=RESET_PC; state=FETCH; all registers 0; mem_req, mem_we, retire, illegal = 0;
//   mem_addr, mem_wdata = 0.
//  Reset during a pending access drops mem_req in the next cycle; the access is abandoned.
//  States and transitions:
//   FETCH:  req read at PC; on ready, IR<=rdata, PC<=PC+4 -> DECODE
//   DECODE: read rs/rt into A/B; compute branch target PC+(sext(imm)<<2) -> EXEC
//   EXEC:   R-type/addi/ori -> WB
//           lw/sw -> MEM, with addr = A+sext(imm)
//           beq: if A==B then PC<=target; retire -> FETCH
//           j: PC<={PC[ADDR_W-1:28], IR[25:0], 2'b00} truncated to ADDR_W; retire -> FETCH
//   MEM:    lw = read request; on ready, MDR<=rdata -> WB
//           sw = write request; on ready, retire -> FETCH
//   WB:     write ALU result (R-type to rd; addi/ori to rt) or MDR (lw to rt); retire -> FETCH
//   TRAP:   on illegal decode; illegal=1; no further requests; exit only by rst
//  Supported set: R-type funct add 0x20, sub 0x22, sll 0x00, or 0x25; addi 0x08 (sext),
//   ori 0x0D (zext), lw 0x23, sw 0x2B, beq 0x04, j 0x02. Any other opcode/funct -> TRAP.
//  Latency with zero-wait memory (FETCH and MEM each 1 cycle):
//   beq/j 3 cycles; R/addi/ori 4; sw 4; lw 5.
//   Each memory wait cycle adds exactly 1 cycle.
//  While mem_req=1 and mem_ready=0: mem_addr, mem_we, mem_wdata held stable; state holds.
//  Register 0 always reads 0; writes to it are discarded.
//  Arithmetic is 32-bit modulo; no overflow exceptions. sll uses shamt IR[10:6].
//  mem_ready while mem_req=0 is ignored.
// CONFIGURATION
//  PERF_CNT_EN defined:
//   two 32-bit counters, cyc_cnt (+1 every non-reset cycle) and ret_cnt (+1 per retire),
//   both cleared by rst and wrapping at 2^32;
//   adds output ports cyc_cnt and ret_cnt (out, 32).
//  PERF_CNT_EN undefined: counters and ports absent; all other behaviour identical.
// TESTING
//  1. rst 2 cycles, RESET_PC=0 -> first request mem_addr=0, mem_we=0.
//     Before that: illegal=0, retire=0.
//  2. Zero-wait memory, program: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2
//     -> r3=2; retire pulses at cycles 4, 8, 12.
//  3. sw r3,8(r0), then lw r4,8(r0), with mem_ready delayed 3 cycles per access
//     -> write at addr 8 data 2; r4=2; request fields stable during waits.
//  4. beq r1,r1,+2 at PC 0x10 -> next fetch 0x1C.
//     j 0x40 -> next fetch 0x100.
//     beq not taken -> next fetch PC+4.
//  5. Opcode 0x3F -> illegal=1, mem_req stays 0.
//     rst -> illegal=0, fetch resumes at RESET_PC.
//  6. addi r0,r0,7 then or r5,r0,r0 -> r5=0.
//     With PERF_CNT_EN: ret_cnt=2 after both retire.

Source files
------------

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core sharing one ALU and one req/ready memory port across FSM states.
// Optional PERF_CNT_EN adds free-running cycle and retired-instruction counters.
module multi_cycle_cpu #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       REG_NUM  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic              retire,
  output logic              illegal
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       ret_cnt
`endif
);

  // state  | meaning
  // FETCH  | read instruction at PC, PC += 4
  // DECODE | read rs/rt into A/B, form branch target
  // EXEC   | ALU op / address calc; beq and j retire here
  // MEM    | lw read or sw write; sw retires here
  // WB     | register write-back, retire
  // TRAP   | unsupported instruction; idle until reset
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_OR, ALU_SLL} alu_op_t;

  localparam int RI_W = $clog2(REG_NUM);
  localparam int NREG = REG_NUM;

  state_t            state, state_nxt;
  alu_op_t           alu_op;
  logic [ADDR_W-1:0] pc, target, maddr;
  logic [31:0]       ir, a, b, mdr, alu_out;
  logic [31:0]       rf [NREG];
  logic [31:0]       alu_a, alu_b, alu_y, sext_imm, pc32, jt32, rs_val, rt_val, wr_data;
  logic [5:0]        op, funct;
  logic [RI_W-1:0]   rs_i, rt_i, rd_i, wr_idx;
  logic is_r, is_add, is_sub, is_sll, is_or, is_addi, is_ori, is_lw, is_sw, is_beq, is_j, legal;

  assign op       = ir[31:26];
  assign funct    = ir[5:0];
  assign rs_i     = ir[20+RI_W:21];
  assign rt_i     = ir[15+RI_W:16];
  assign rd_i     = ir[10+RI_W:11];
  assign sext_imm = {{16{ir[15]}}, ir[15:0]};
  assign pc32     = 32'(pc);
  assign jt32     = {pc32[31:28], ir[25:0], 2'b00};

  assign is_r    = (op == 6'h00);
  assign is_add  = is_r && (funct == 6'h20);
  assign is_sub  = is_r && (funct == 6'h22);
  assign is_sll  = is_r && (funct == 6'h00);
  assign is_or   = is_r && (funct == 6'h25);
  assign is_addi = (op == 6'h08);
  assign is_ori  = (op == 6'h0D);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign is_beq  = (op == 6'h04);
  assign is_j    = (op == 6'h02);
  assign legal   = is_add | is_sub | is_sll | is_or | is_addi | is_ori |
                   is_lw | is_sw | is_beq | is_j;

  assign rs_val  = (rs_i == '0) ? '0 : rf[rs_i];
  assign rt_val  = (rt_i == '0) ? '0 : rf[rt_i];
  assign wr_idx  = is_r ? rd_i : rt_i;
  assign wr_data = is_lw ? mdr : alu_out;

  // Shared ALU: PC+4 in FETCH, branch target in DECODE, instruction op in EXEC.
  always_comb begin
    alu_a  = pc32;
    alu_b  = 32'd4;
    alu_op = ALU_ADD;
    case (state)
      S_DECODE: alu_b = {sext_imm[29:0], 2'b00};
      S_EXEC: begin
        alu_a = a;
        alu_b = sext_imm;
        if (is_r) begin
          alu_b = b;
          if (is_sub) alu_op = ALU_SUB;
          else if (is_or) alu_op = ALU_OR;
          else if (is_sll) begin
            alu_op = ALU_SLL;
            alu_a  = b;
            alu_b  = {27'd0, ir[10:6]};
          end
        end else if (is_ori) begin
          alu_op = ALU_OR;
          alu_b  = {16'd0, ir[15:0]};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLL: alu_y = alu_a << alu_b[4:0];
      default: alu_y = alu_a + alu_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: state_nxt = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_lw || is_sw)       state_nxt = S_MEM;
        else if (is_beq || is_j)  state_nxt = S_FETCH;
        else                      state_nxt = S_WB;
      end
      S_MEM:    if (mem_ready) state_nxt = is_sw ? S_FETCH : S_WB;
      S_WB:     state_nxt = S_FETCH;
      default:  state_nxt = S_TRAP;
    endcase
  end

  // Outputs are gated by rst so a pending access is dropped while reset is held.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    retire    = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_addr = {pc[ADDR_W-1:2], 2'b00};
        end
        S_EXEC: retire = is_beq | is_j;
        S_MEM: begin
          mem_req  = 1'b1;
          mem_addr = maddr;
          mem_we   = is_sw;
          if (is_sw) begin
            mem_wdata = b;
            retire    = mem_ready;
          end
        end
        S_WB:    retire = 1'b1;
        default: ;
      endcase
    end
  end

  assign illegal = (state == S_TRAP);
  assign pc_out  = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      mdr     <= '0;
      alu_out <= '0;
      target  <= '0;
      maddr   <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem_ready) begin
          ir <= mem_rdata;
          pc <= alu_y[ADDR_W-1:0];
        end
        S_DECODE: begin
          a      <= rs_val;
          b      <= rt_val;
          target <= alu_y[ADDR_W-1:0];
        end
        S_EXEC: begin
          alu_out <= alu_y;
          maddr   <= {alu_y[ADDR_W-1:2], 2'b00};
          if (is_beq && (a == b)) pc <= target;
          if (is_j)               pc <= jt32[ADDR_W-1:0];
        end
        S_MEM: if (mem_ready && !is_sw) mdr <= mem_rdata;
        S_WB:  if (wr_idx != '0) rf[wr_idx] <= wr_data;
        default: ;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (retire) ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Self-checking bench for multi_cycle_cpu: TB-side memory with random wait states and an
// instruction-level reference model (architectural PC/registers/memory plus per-class latency).
module tb_multi_cycle_cpu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req, mem_we, retire, illegal;
  logic [31:0] mem_addr, mem_wdata, pc_out;
`ifdef PERF_CNT_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  multi_cycle_cpu dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc_out(pc_out), .retire(retire), .illegal(illegal)
`ifdef PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int ret_total = 0;
  int n_wr = 0;

  logic [31:0] mem    [0:1023];
  logic [31:0] refmem [0:1023];
  logic [31:0] ref_regs [0:31];
  logic [31:0] ref_pc;
  logic [31:0] fetch_log [0:63];
  int          ret_cyc   [0:63];
  logic [31:0] wlog_addr [0:63];
  logic [31:0] wlog_data [0:63];

  function automatic logic [31:0] enc_r(input logic [5:0] f, input int rs, input int rt,
                                        input int rd, input int sh);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0;
      refmem[i] = '0;
    end
    n_wr = 0;
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    mem[addr[11:2]] = w;
    refmem[addr[11:2]] = w;
  endtask

  task automatic do_reset();
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ref_pc = '0;
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    ret_total = 0;
  endtask

  // Executes one instruction architecturally; returns zero-wait latency and store info.
  task automatic ref_step(output int base, output bit st, output logic [31:0] sa,
                          output logic [31:0] sd);
    logic [31:0] w, pc4, s_imm, z_imm, ea, rsv, rtv;
    w     = refmem[ref_pc[11:2]];
    pc4   = ref_pc + 32'd4;
    rsv   = ref_regs[w[25:21]];
    rtv   = ref_regs[w[20:16]];
    s_imm = {{16{w[15]}}, w[15:0]};
    z_imm = {16'h0, w[15:0]};
    ea    = rsv + s_imm;
    st = 1'b0; sa = '0; sd = '0; base = 4;
    ref_pc = pc4;
    case (w[31:26])
      6'h00: case (w[5:0])
        6'h20: ref_regs[w[15:11]] = rsv + rtv;
        6'h22: ref_regs[w[15:11]] = rsv - rtv;
        6'h00: ref_regs[w[15:11]] = rtv << w[10:6];
        6'h25: ref_regs[w[15:11]] = rsv | rtv;
        default: ;
      endcase
      6'h08: ref_regs[w[20:16]] = rsv + s_imm;
      6'h0D: ref_regs[w[20:16]] = rsv | z_imm;
      6'h23: begin ref_regs[w[20:16]] = refmem[ea[11:2]]; base = 5; end
      6'h2B: begin refmem[ea[11:2]] = rtv; st = 1'b1; sa = {ea[31:2], 2'b00}; sd = rtv; end
      6'h04: begin base = 3; if (rsv == rtv) ref_pc = pc4 + (s_imm << 2); end
      6'h02: begin base = 3; ref_pc = {pc4[31:28], w[25:0], 2'b00}; end
      default: ;
    endcase
    ref_regs[0] = '0;
  endtask

  // Serves memory with wmin..wmax wait cycles per access until n instructions retire.
  task automatic run_prog(input int n, input int wmin, input int wmax, input bit idle_noise);
    int cyc = 0, first = -1, retired = 0, lat = 0, waits = 0, wleft = 0, base = 0;
    bit in_instr = 0, busy = 0, st = 0, wrote = 0;
    logic [31:0] h_addr = '0, h_wdata = '0, sa, sd, exp_pc;
    logic h_we = 1'b0;
    while (retired < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (mem_req && !in_instr) begin
        in_instr = 1; lat = 0; waits = 0;
        if (retired < 64) fetch_log[retired] = mem_addr;
        if (first < 0) first = cyc;
      end
      if (in_instr) lat++;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      wrote = 0;
      if (mem_req) begin
        if (!busy) begin
          busy = 1; wleft = $urandom_range(wmax, wmin);
          h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
        end else begin
          n_checks++;
          if ({mem_addr, mem_we, mem_wdata} !== {h_addr, h_we, h_wdata})
            $display("FAIL req_stable got %h/%b/%h want %h/%b/%h",
                     mem_addr, mem_we, mem_wdata, h_addr, h_we, h_wdata);
          else n_pass++;
        end
        if (wleft == 0) begin
          mem_ready = 1'b1; busy = 0;
          if (h_we) begin
            mem[h_addr[11:2]] = h_wdata; wrote = 1;
            if (n_wr < 64) begin wlog_addr[n_wr] = h_addr; wlog_data[n_wr] = h_wdata; end
            n_wr++;
          end else mem_rdata = mem[h_addr[11:2]];
        end else begin
          wleft--; waits++;
        end
      end else if (idle_noise) mem_ready = 1'($urandom_range(1, 0));
      #1;
      if (retire) begin
        exp_pc = ref_pc;
        ref_step(base, st, sa, sd);
        n_checks++;
        if (retired < 64 && fetch_log[retired] !== exp_pc)
          $display("FAIL fetch_pc got %h want %h", fetch_log[retired], exp_pc);
        else n_pass++;
        n_checks++;
        if (lat !== base + waits) $display("FAIL latency got %0d want %0d", lat, base + waits);
        else n_pass++;
        n_checks++;
        if (wrote !== st || (st && {h_addr, h_wdata} !== {sa, sd}))
          $display("FAIL store got %b %h %h want %b %h %h", wrote, h_addr, h_wdata, st, sa, sd);
        else n_pass++;
`ifdef PERF_CNT_EN
        n_checks++;
        if (ret_cnt !== 32'(ret_total)) $display("FAIL ret_cnt got %0d want %0d", ret_cnt, ret_total);
        else n_pass++;
`endif
        ret_total++;
        if (retired < 64) ret_cyc[retired] = cyc - first + 1;
        retired++;
        in_instr = 0;
      end
    end
    mem_ready = 1'b0;
    n_checks++;
    if (retired < n) $display("FAIL run_timeout got %0d retires want %0d", retired, n);
    else n_pass++;
  endtask

  task automatic test_reset();
    clear_mem();
    put(32'h0, enc_i(6'h08, 0, 1, 16'd5));
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_req, mem_we, retire, illegal, mem_addr, mem_wdata, pc_out} !== 99'd0)
      $display("FAIL reset_outputs got %b%b%b%b %h %h %h want 0", mem_req, mem_we, retire,
               illegal, mem_addr, mem_wdata, pc_out);
    else n_pass++;
`ifdef PERF_CNT_EN
    n_checks++;
    if ({cyc_cnt, ret_cnt} !== 64'd0) $display("FAIL reset_cnt got %h %h want 0", cyc_cnt, ret_cnt);
    else n_pass++;
`endif
    rst = 1'b0;
    ref_pc = '0;
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    ret_total = 0;
    #1;
    n_checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h0})
      $display("FAIL first_fetch got %b %b %h want 1 0 0", mem_req, mem_we, mem_addr);
    else n_pass++;
    run_prog(1, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if ({mem_req, mem_addr, pc_out} !== {1'b1, 32'h4, 32'h4})
      $display("FAIL pending_fetch got %b %h %h want 1 4 4", mem_req, mem_addr, pc_out);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({mem_req, pc_out} !== {1'b0, 32'h0})
      $display("FAIL abort_access got %b %h want 0 0", mem_req, pc_out);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h0})
      $display("FAIL refetch got %b %h want 1 0", mem_req, mem_addr);
    else n_pass++;
  endtask

  task automatic test_alu_zero_wait();
    clear_mem();
    put(32'h0, enc_i(6'h08, 0, 1, 16'd5));
    put(32'h4, enc_i(6'h08, 0, 2, 16'hFFFD));
    put(32'h8, enc_r(6'h20, 1, 2, 3, 0));
    put(32'hC, enc_i(6'h2B, 0, 3, 16'h0200));
    do_reset();
    run_prog(4, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ret_cyc[i] !== 4 * (i + 1))
        $display("FAIL retire_cycle[%0d] got %0d want %0d", i, ret_cyc[i], 4 * (i + 1));
      else n_pass++;
    end
    n_checks++;
    if (mem[128] !== 32'd2) $display("FAIL r3_value got %h want 2", mem[128]);
    else n_pass++;
  endtask

  task automatic test_mem_wait();
    clear_mem();
    put(32'h00, enc_i(6'h08, 0, 1, 16'd5));
    put(32'h04, enc_i(6'h08, 0, 2, 16'hFFFD));
    put(32'h08, enc_r(6'h20, 1, 2, 3, 0));
    put(32'h0C, enc_i(6'h2B, 0, 3, 16'd8));
    put(32'h10, enc_i(6'h23, 0, 4, 16'd8));
    put(32'h14, enc_i(6'h2B, 0, 4, 16'h0200));
    do_reset();
    run_prog(6, 3, 3, 0);
    n_checks++;
    if ({wlog_addr[0], wlog_data[0]} !== {32'd8, 32'd2})
      $display("FAIL sw_fields got %h %h want 8 2", wlog_addr[0], wlog_data[0]);
    else n_pass++;
    n_checks++;
    if (mem[128] !== 32'd2) $display("FAIL lw_value got %h want 2", mem[128]);
    else n_pass++;
  endtask

  task automatic test_branch_jump();
    clear_mem();
    put(32'h000, enc_i(6'h08, 0, 1, 16'd5));
    put(32'h010, enc_i(6'h04, 1, 1, 16'd2));
    put(32'h014, enc_i(6'h08, 0, 9, 16'd1));
    put(32'h018, enc_i(6'h08, 0, 9, 16'd2));
    put(32'h01C, enc_j(26'h40));
    put(32'h100, enc_i(6'h04, 1, 0, 16'd3));
    put(32'h104, enc_i(6'h2B, 0, 1, 16'h0200));
    do_reset();
    run_prog(8, 0, 2, 1);
    n_checks++;
    if (fetch_log[5] !== 32'h1C) $display("FAIL beq_taken got %h want 1c", fetch_log[5]);
    else n_pass++;
    n_checks++;
    if (fetch_log[6] !== 32'h100) $display("FAIL jump got %h want 100", fetch_log[6]);
    else n_pass++;
    n_checks++;
    if (fetch_log[7] !== 32'h104) $display("FAIL beq_not_taken got %h want 104", fetch_log[7]);
    else n_pass++;
  endtask

  task automatic test_illegal(input logic [31:0] word);
    int reqs = 0, rets = 0;
    clear_mem();
    put(32'h0, word);
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = mem[mem_addr[11:2]];
      if (mem_req) reqs++;
      #1;
      if (retire) rets++;
    end
    mem_ready = 1'b0;
    n_checks++;
    if ({illegal, reqs, rets} !== {1'b1, 32'd1, 32'd0})
      $display("FAIL trap got illegal=%b reqs=%0d rets=%0d want 1 1 0", illegal, reqs, rets);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({illegal, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h0})
      $display("FAIL trap_exit got %b %b %h want 0 1 0", illegal, mem_req, mem_addr);
    else n_pass++;
  endtask

  task automatic test_r0();
    clear_mem();
    put(32'h0, enc_i(6'h08, 0, 0, 16'd7));
    put(32'h4, enc_r(6'h25, 0, 0, 5, 0));
    put(32'h8, enc_i(6'h2B, 0, 5, 16'h0200));
    put(32'hC, enc_i(6'h2B, 0, 0, 16'h0204));
    put(32'h200, 32'hDEADBEEF);
    put(32'h204, 32'hCAFEF00D);
    do_reset();
    run_prog(4, 0, 1, 1);
    n_checks++;
    if ({mem[128], mem[129]} !== 64'd0)
      $display("FAIL r0_discard got %h %h want 0 0", mem[128], mem[129]);
    else n_pass++;
  endtask

  task automatic test_random();
    int idx = 0, kind;
    logic [5:0] fsel [4];
    fsel[0] = 6'h20; fsel[1] = 6'h22; fsel[2] = 6'h00; fsel[3] = 6'h25;
    clear_mem();
    for (int k = 0; k < 30; k++) begin
      kind = $urandom_range(5, 0);
      case (kind)
        0: put(32'(idx * 4), enc_r(fsel[$urandom_range(3, 0)], $urandom_range(7, 0),
                                   $urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(31, 0)));
        1: put(32'(idx * 4), enc_i(6'h08, $urandom_range(7, 0), $urandom_range(7, 0), 16'($urandom)));
        2: put(32'(idx * 4), enc_i(6'h0D, $urandom_range(7, 0), $urandom_range(7, 0), 16'($urandom)));
        3: put(32'(idx * 4), enc_i(6'h2B, 0, $urandom_range(7, 0), 16'(32'h200 + 4 * $urandom_range(15, 0))));
        4: put(32'(idx * 4), enc_i(6'h23, 0, $urandom_range(7, 0), 16'(32'h200 + 4 * $urandom_range(15, 0))));
        default: put(32'(idx * 4), enc_i(6'h04, $urandom_range(3, 0), $urandom_range(3, 0), 16'd1));
      endcase
      idx++;
    end
    for (int r = 1; r < 8; r++) begin
      put(32'(idx * 4), enc_i(6'h2B, 0, r, 16'(32'h300 + 4 * r)));
      idx++;
    end
    put(32'(idx * 4), enc_j(26'(idx)));
    do_reset();
    run_prog(idx + 3, 0, 3, 1);
    for (int i = 128; i < 208; i++) begin
      n_checks++;
      if (mem[i] !== refmem[i]) $display("FAIL data_word[%0d] got %h want %h", i, mem[i], refmem[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_alu_zero_wait();
    test_mem_wait();
    test_branch_jump();
    test_illegal(32'hFC000000);
    test_illegal(enc_r(6'h21, 1, 2, 3, 0));
    test_illegal(enc_i(6'h09, 1, 2, 16'd4));
    test_r0();
    repeat (3) test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
